// File: rtl/ids_pkg.sv
// Shared constants and width helpers for the multi-channel debounced LED gate.
package ids_pkg;

    localparam logic MODE_LEVEL  = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;

    // Bits needed to hold counts 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ids_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one switch bit.
module ids_debounce
    import ids_pkg::*;
#(
    parameter int unsigned DB_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    localparam int unsigned KW = cnt_w(DB_CYC);

    logic          sync1_q, sync2_q;
    logic          s_q, s_d;
    logic [KW-1:0] k_q, k_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            s_q     <= 1'b0;
            k_q     <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
            s_q     <= s_d;
            k_q     <= k_d;
        end
    end

    // Any cycle where the synced input matches the stable value restarts the count.
    always_comb begin
        s_d = s_q;
        k_d = '0;
        if (sync2_q != s_q) begin
            if (k_q == KW'(DB_CYC - 1)) begin
                s_d = sync2_q;
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    assign out = s_q;

endmodule

// File: rtl/ids_led_gate.sv
// Multi-channel debounced switch-to-LED gate with level/toggle modes and lit count.
// Optional blinking of toggle-mode LEDs is enabled by defining IDS_LED_GATE_BLINK_EN.
module ids_led_gate
    import ids_pkg::*;
#(
    parameter int unsigned CH        = 4,
    parameter int unsigned DB_CYC    = 16,
    parameter int unsigned BLINK_DIV = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CH-1:0]          c,
    input  logic [CH-1:0]          d,
    input  logic                   mode,
    input  logic                   clr,
    output logic [CH-1:0]          led_,
    output logic [$clog2(CH+1)-1:0] active_cnt
);

    localparam int unsigned CW = $clog2(CH + 1);

    logic [CH-1:0] cs, ds, g;
    logic [CH-1:0] g_q;
    logic [CH-1:0] lat_q, lat_d;
    logic [CH-1:0] lit, led_d, led_q;
    logic [CW-1:0] cnt_d, cnt_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        ids_debounce #(
            .DB_CYC (DB_CYC)
        ) u_db_c (
            .clk   (clk),
            .rst_n (rst_n),
            .in    (c[i]),
            .out   (cs[i])
        );

        ids_debounce #(
            .DB_CYC (DB_CYC)
        ) u_db_d (
            .clk   (clk),
            .rst_n (rst_n),
            .in    (d[i]),
            .out   (ds[i])
        );
    end

    assign g = ~cs & ds;

`ifdef IDS_LED_GATE_BLINK_EN
    logic [BLINK_DIV-1:0] presc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + BLINK_DIV'(1);
        end
    end
`else
    // No prescaler in this build; BLINK_DIV is only referenced here.
    if (BLINK_DIV == 0) begin : g_no_blink
    end
`endif

    // Latches track gate edges in both modes; clear wins over a same-cycle edge.
    always_comb begin
        lat_d = lat_q ^ (g & ~g_q);
        if (clr) begin
            lat_d = '0;
        end
    end

    always_comb begin
        lit   = (mode == MODE_TOGGLE) ? lat_d : g;
        led_d = lit;
`ifdef IDS_LED_GATE_BLINK_EN
        if (mode == MODE_TOGGLE) begin
            led_d = lat_d & {CH{presc_q[BLINK_DIV-1]}};
        end
`endif
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < CH; i++) begin
            cnt_d = cnt_d + CW'(lit[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g_q   <= '0;
            lat_q <= '0;
            led_q <= '0;
            cnt_q <= '0;
        end else begin
            g_q   <= g;
            lat_q <= lat_d;
            led_q <= led_d;
            cnt_q <= cnt_d;
        end
    end

    assign led_       = led_q;
    assign active_cnt = cnt_q;

endmodule

// File: tb/tb_ids_led_gate.sv
// Directed self-checking bench for ids_led_gate with CH=4, DB_CYC=4, BLINK_DIV=3.
module tb_ids_led_gate;

    logic       clk;
    logic       rst_n;
    logic [3:0] c, d;
    logic       mode, clr;
    logic [3:0] led_;
    logic [2:0] active_cnt;

    int checks;
    int failures;

    ids_led_gate #(
        .CH        (4),
        .DB_CYC    (4),
        .BLINK_DIV (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .c          (c),
        .d          (d),
        .mode       (mode),
        .clr        (clr),
        .led_       (led_),
        .active_cnt (active_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IDS_LED_GATE_BLINK_EN
    // Reference prescaler: blink_msb holds the MSB the DUT used at the last edge.
    logic [2:0] presc;
    logic       blink_msb;
    always @(posedge clk) begin
        blink_msb <= presc[2];
        presc     <= rst_n ? presc + 3'd1 : 3'd0;
    end
`endif

    function automatic logic [3:0] tog_exp(input logic [3:0] lat);
`ifdef IDS_LED_GATE_BLINK_EN
        return lat & {4{blink_msb}};
`else
        return lat;
`endif
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        c        = 4'b0000;
        d        = 4'b1111;
        mode     = 1'b0;
        clr      = 1'b0;

        // Reset, then release with all gates open.
        step(3);
        check("rst_led", 8'(led_), 8'h0);
        check("rst_cnt", 8'(active_cnt), 8'd0);
        rst_n = 1'b1;
        step(6);
        check("rel_led_e6", 8'(led_), 8'h0);
        step(1);
        check("rel_led_e7", 8'(led_), 8'hF);
        check("rel_cnt_e7", 8'(active_cnt), 8'd4);

        // Level gate.
        c = 4'b0101;
        d = 4'b0011;
        step(7);
        check("lvl_led", 8'(led_), 8'h2);
        check("lvl_cnt", 8'(active_cnt), 8'd1);
        c = 4'b0111;
        step(6);
        check("lvl_inh_e6", 8'(led_), 8'h2);
        step(1);
        check("lvl_inh_e7", 8'(led_), 8'h0);
        check("lvl_inh_cnt", 8'(active_cnt), 8'd0);

        // Glitch reject, then accept.
        c = 4'b0000;
        d = 4'b0000;
        step(8);
        check("gl_idle", 8'(led_), 8'h0);
        d = 4'b0001;
        step(3);
        d = 4'b0000;
        step(10);
        check("gl_short", 8'(led_), 8'h0);
        d = 4'b0001;
        step(6);
        check("gl_long_e6", 8'(led_), 8'h0);
        step(1);
        check("gl_long_e7", 8'(led_), 8'h1);
        check("gl_long_cnt", 8'(active_cnt), 8'd1);

        // Toggle mode on channel 2.
        d = 4'b0000;
        step(8);
        mode = 1'b1;
        clr  = 1'b1;
        step(1);
        clr = 1'b0;
        check("tg_clr", 8'(led_), 8'(tog_exp(4'b0000)));
        for (int r = 0; r < 3; r++) begin
            d = 4'b0100;
            step(6);
            check("tg_pre", 8'(led_), 8'(tog_exp((r % 2 == 1) ? 4'b0100 : 4'b0000)));
            step(1);
            check("tg_rise", 8'(led_), 8'(tog_exp((r % 2 == 0) ? 4'b0100 : 4'b0000)));
            check("tg_cnt", 8'(active_cnt), (r % 2 == 0) ? 8'd1 : 8'd0);
            d = 4'b0000;
            step(8);
            check("tg_fall", 8'(led_), 8'(tog_exp((r % 2 == 0) ? 4'b0100 : 4'b0000)));
        end
        d = 4'b0100;
        step(6);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("tg_clr_edge", 8'(led_), 8'h0);
        check("tg_clr_cnt", 8'(active_cnt), 8'd0);
        step(8);
        check("tg_clr_hold", 8'(led_), 8'h0);

        // Mode switch with latched state.
        mode = 1'b0;
        step(1);
        check("ms_level", 8'(led_), 8'h4);
        d = 4'b0000;
        step(8);
        d = 4'b1010;
        step(8);
        check("ms_lvl_a", 8'(led_), 8'hA);
        d = 4'b0000;
        step(8);
        check("ms_lvl_off", 8'(led_), 8'h0);
        check("ms_lvl_cnt", 8'(active_cnt), 8'd0);
        mode = 1'b1;
        step(1);
        check("ms_tog_led", 8'(led_), 8'(tog_exp(4'b1010)));
        check("ms_tog_cnt", 8'(active_cnt), 8'd2);

        // Reset with a partial debounce count in flight.
        d = 4'b0001;
        step(4);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("rm_led", 8'(led_), 8'h0);
        check("rm_cnt", 8'(active_cnt), 8'd0);
        step(6);
        check("rm_e6", 8'(led_), 8'h0);
        step(1);
        check("rm_e7", 8'(led_), 8'(tog_exp(4'b0001)));
        check("rm_e7_cnt", 8'(active_cnt), 8'd1);

        // Steady toggle output (blinks when the prescaler is built in).
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("bl_led", 8'(led_), 8'(tog_exp(4'b0001)));
            check("bl_cnt", 8'(active_cnt), 8'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
